// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS-32 pipeline hazard sequencer: FSM state encoding
// and the default register-specifier width.
package mips_pipe_pkg;

  localparam int REG_W_DEF = 5;

  localparam logic [1:0] ENC_INIT     = 2'b00;
  localparam logic [1:0] ENC_RUN      = 2'b01;
  localparam logic [1:0] ENC_MEM_WAIT = 2'b10;
  localparam logic [1:0] ENC_HALT     = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT     = ENC_INIT,
    ST_RUN      = ENC_RUN,
    ST_MEM_WAIT = ENC_MEM_WAIT,
    ST_HALT     = ENC_HALT
  } hz_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register the ID instruction
// reads. Register 0 is hard-wired zero and never creates a dependency.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             i_idex_mem_read,
  input  logic [REG_W-1:0] i_idex_rt,
  input  logic [REG_W-1:0] i_ifid_rs,
  input  logic [REG_W-1:0] i_ifid_rt,
  input  logic             i_ifid_uses_rt,
  output logic             o_load_use
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_idex_rt == i_ifid_rs);
  assign w_rt_match = i_ifid_uses_rt && (i_idex_rt == i_ifid_rt);
  assign o_load_use = i_idex_mem_read && (i_idex_rt != '0) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (INIT/RUN/MEM_WAIT/HALT).
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int INIT_FLUSH  = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             ex_branch_taken,
  input  logic             exmem_mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             pc_sel_branch,
  output logic             mem_timeout,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      squash_events
);

  localparam int              INIT_W        = (INIT_FLUSH > 1) ? $clog2(INIT_FLUSH) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST   = INIT_W'(INIT_FLUSH - 1);
  localparam logic [TO_W:0]   TO_LIMIT      = (TO_W + 1)'(MEM_TIMEOUT);
  localparam bit              FIRST_WAIT_HALTS = (MEM_TIMEOUT <= 1);

  hz_state_e         r_state, w_state_nxt;
  logic [INIT_W-1:0] r_init_cnt, w_init_cnt_nxt;
  logic [TO_W-1:0]   r_to_cnt, w_to_cnt_nxt;
  logic              r_mem_timeout, w_mem_timeout_nxt;
  logic [TO_W:0]     w_to_sum;
  logic              w_load_use;
  logic              w_freeze;
  logic              w_run_rules;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .i_idex_mem_read (idex_mem_read),
    .i_idex_rt       (idex_rt),
    .i_ifid_rs       (ifid_rs),
    .i_ifid_rt       (ifid_rt),
    .i_ifid_uses_rt  (ifid_uses_rt),
    .o_load_use      (w_load_use)
  );

  assign w_to_sum = {1'b0, r_to_cnt} + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_INIT;
      r_init_cnt    <= '0;
      r_to_cnt      <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_init_cnt    <= w_init_cnt_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_mem_timeout <= w_mem_timeout_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_init_cnt_nxt    = r_init_cnt;
    w_to_cnt_nxt      = r_to_cnt;
    w_mem_timeout_nxt = r_mem_timeout;
    w_freeze          = 1'b0;
    w_run_rules       = 1'b0;
    pc_en             = 1'b0;
    ifid_en           = 1'b0;
    idex_en           = 1'b0;
    exmem_en          = 1'b0;
    memwb_en          = 1'b0;
    ifid_flush        = 1'b0;
    idex_flush        = 1'b0;
    exmem_flush       = 1'b0;
    memwb_flush       = 1'b0;
    pc_sel_branch     = 1'b0;

    case (r_state)
      ST_INIT: begin
        {ifid_en, idex_en, exmem_en, memwb_en}             = 4'hF;
        {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'hF;
        if (r_init_cnt == INIT_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_init_cnt_nxt = r_init_cnt + INIT_W'(1);
        end
      end
      ST_RUN: begin
        w_to_cnt_nxt = '0;
        if (exmem_mem_req && !dmem_ready) begin
          w_freeze     = 1'b1;
          w_to_cnt_nxt = TO_W'(1);
          if (FIRST_WAIT_HALTS) begin
            w_state_nxt       = ST_HALT;
            w_mem_timeout_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_MEM_WAIT;
          end
        end else begin
          w_run_rules = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          w_freeze     = 1'b1;
          w_to_cnt_nxt = w_to_sum[TO_W-1:0];
          if (w_to_sum >= TO_LIMIT) begin
            w_state_nxt       = ST_HALT;
            w_mem_timeout_nxt = 1'b1;
          end
        end else begin
          // The branch held in the frozen EX stage is applied on this cycle.
          w_run_rules  = 1'b1;
          w_to_cnt_nxt = '0;
          w_state_nxt  = ST_RUN;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase

    if (w_freeze) begin
      memwb_en    = 1'b1;
      memwb_flush = 1'b1;
    end

    if (w_run_rules) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'h1F;
      if (ex_branch_taken) begin
        pc_sel_branch = 1'b1;
        ifid_flush    = 1'b1;
        idex_flush    = 1'b1;
      end else if (w_load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end

    if (!reset_n) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en}      = 5'h00;
      {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'hF;
      pc_sel_branch                                      = 1'b0;
    end
  end

  assign mem_timeout = r_mem_timeout;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_squash_events;
  logic        w_count_stall;

  assign w_count_stall = ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT)) && !pc_en;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles  <= '0;
      r_squash_events <= '0;
    end else begin
      if (w_count_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (pc_sel_branch && (r_squash_events != '1)) begin
        r_squash_events <= r_squash_events + 32'd1;
      end
    end
  end

  assign stall_cycles  = r_stall_cycles;
  assign squash_events = r_squash_events;
`else
  assign stall_cycles  = '0;
  assign squash_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int REG_W       = 5;
  localparam int INIT_FLUSH  = 2;
  localparam int MEM_TIMEOUT = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [REG_W-1:0] ifid_rs, ifid_rt, idex_rt;
  logic             ifid_uses_rt, idex_mem_read, ex_branch_taken, exmem_mem_req, dmem_ready;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic             pc_sel_branch, mem_timeout;
  logic [31:0]      stall_cycles, squash_events;

  pipe_hazard_ctrl #(
    .REG_W(REG_W), .INIT_FLUSH(INIT_FLUSH), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(8)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ex_branch_taken(ex_branch_taken), .exmem_mem_req(exmem_mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .pc_sel_branch(pc_sel_branch), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .squash_events(squash_events)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: cycles of init flush left, consecutive wait cycles, halt flag.
  int          m_init_left;
  int          m_wait;
  bit          m_halted;
  bit          m_mto;
  logic [31:0] m_stall;
  logic [31:0] m_squash;
  bit          m_mem_stall;
  logic [4:0]  e_en;     // {pc, ifid, idex, exmem, memwb}
  logic [3:0]  e_flush;  // {ifid, idex, exmem, memwb}
  logic        e_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit lu, waiting;
    if (!reset_n) begin
      m_init_left = INIT_FLUSH;
      m_wait      = 0;
      m_halted    = 1'b0;
      m_mto       = 1'b0;
      m_stall     = 32'd0;
      m_squash    = 32'd0;
    end
    e_en        = 5'b00000;
    e_flush     = 4'b0000;
    e_sel       = 1'b0;
    m_mem_stall = 1'b0;
    if (!reset_n) begin
      e_flush = 4'b1111;
    end else if (m_init_left > 0) begin
      e_en    = 5'b01111;
      e_flush = 4'b1111;
    end else if (!m_halted) begin
      waiting     = (m_wait > 0);
      m_mem_stall = waiting ? !dmem_ready : (exmem_mem_req && !dmem_ready);
      lu = idex_mem_read && (idex_rt != 0) &&
           ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
      if (m_mem_stall) begin
        e_en    = 5'b00001;
        e_flush = 4'b0001;
      end else if (ex_branch_taken) begin
        e_en    = 5'b11111;
        e_flush = 4'b1100;
        e_sel   = 1'b1;
      end else if (lu) begin
        e_en    = 5'b00111;
        e_flush = 4'b0100;
      end else begin
        e_en = 5'b11111;
      end
    end
  endtask

  task automatic model_advance();
    if (!reset_n) return;
    if (m_init_left > 0) begin
      m_init_left--;
    end else if (!m_halted) begin
      if (!e_en[4] && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (e_sel && m_squash != 32'hFFFF_FFFF) m_squash++;
      if (m_mem_stall) begin
        m_wait++;
        if (m_wait >= MEM_TIMEOUT) begin
          m_halted = 1'b1;
          m_mto    = 1'b1;
        end
      end else begin
        m_wait = 0;
      end
    end
  endtask

  // Settle after inputs changed at the negedge, then compare every output with the model.
  task automatic settle_and_compare();
    #1;
    model_eval();
    check("enables", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {27'd0, e_en});
    check("flushes", {28'd0, ifid_flush, idex_flush, exmem_flush, memwb_flush}, {28'd0, e_flush});
    check("pc_sel_branch", {31'd0, pc_sel_branch}, {31'd0, e_sel});
    check("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_mto});
    check("stall_cycles", stall_cycles, PERF_ON ? m_stall : 32'd0);
    check("squash_events", squash_events, PERF_ON ? m_squash : 32'd0);
  endtask

  task automatic finish_cycle();
    model_advance();
    @(negedge clock);
  endtask

  task automatic step();
    settle_and_compare();
    finish_cycle();
  endtask

  task automatic idle_inputs();
    ifid_rs = '0; ifid_rt = '0; idex_rt = '0;
    ifid_uses_rt = 1'b0; idex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    exmem_mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clock);
    settle_and_compare();
    check("rst_pc_en", {31'd0, pc_en}, 32'd0);
    check("rst_memwb_flush", {31'd0, memwb_flush}, 32'd1);
    finish_cycle();
    reset_n = 1'b1;

    // Two init flush cycles, RUN on the third.
    settle_and_compare();
    check("init1_pc_en", {31'd0, pc_en}, 32'd0);
    check("init1_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    finish_cycle();
    settle_and_compare();
    check("init2_exmem_flush", {31'd0, exmem_flush}, 32'd1);
    finish_cycle();
    settle_and_compare();
    check("run_pc_en", {31'd0, pc_en}, 32'd1);
    check("run_idex_flush", {31'd0, idex_flush}, 32'd0);
    finish_cycle();

    // Load-use on rs: one stall cycle.
    idex_mem_read = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    settle_and_compare();
    check("lu_pc_en", {31'd0, pc_en}, 32'd0);
    check("lu_ifid_en", {31'd0, ifid_en}, 32'd0);
    check("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
    check("lu_exmem_en", {31'd0, exmem_en}, 32'd1);
    finish_cycle();
    idex_mem_read = 1'b0;
    settle_and_compare();
    check("lu_after_pc_en", {31'd0, pc_en}, 32'd1);
    finish_cycle();

    // Load into r0 never stalls.
    idex_mem_read = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
    settle_and_compare();
    check("lu_r0_pc_en", {31'd0, pc_en}, 32'd1);
    finish_cycle();

    // rt dependency only counts when the ID instruction reads rt.
    idex_rt = 5'd7; ifid_rt = 5'd7; ifid_rs = 5'd3; ifid_uses_rt = 1'b1;
    step();
    ifid_uses_rt = 1'b0;
    settle_and_compare();
    check("lu_rt_unused_pc_en", {31'd0, pc_en}, 32'd1);
    finish_cycle();

    // Branch together with a load-use: branch wins, one cycle only.
    ifid_uses_rt = 1'b1; ex_branch_taken = 1'b1;
    settle_and_compare();
    check("br_sel", {31'd0, pc_sel_branch}, 32'd1);
    check("br_flushes", {28'd0, ifid_flush, idex_flush, exmem_flush, memwb_flush}, 32'hC);
    check("br_pc_en", {31'd0, pc_en}, 32'd1);
    finish_cycle();
    idle_inputs();
    settle_and_compare();
    check("br_after_sel", {31'd0, pc_sel_branch}, 32'd0);
    check("perf_stall_2", stall_cycles, PERF_ON ? 32'd2 : 32'd0);
    check("perf_squash_1", squash_events, PERF_ON ? 32'd1 : 32'd0);
    finish_cycle();

    // Three frozen cycles, then ready releases the deferred branch.
    exmem_mem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle_and_compare();
      check("mw_pc_en", {31'd0, pc_en}, 32'd0);
      check("mw_memwb_flush", {31'd0, memwb_flush}, 32'd1);
      check("mw_sel", {31'd0, pc_sel_branch}, 32'd0);
      finish_cycle();
    end
    dmem_ready = 1'b1;
    settle_and_compare();
    check("mw_release_sel", {31'd0, pc_sel_branch}, 32'd1);
    check("mw_release_exmem_en", {31'd0, exmem_en}, 32'd1);
    finish_cycle();
    idle_inputs();
    step();

    // Timeout: four wait cycles then HALT with sticky flag.
    exmem_mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle_and_compare();
      check("to_wait_mto", {31'd0, mem_timeout}, 32'd0);
      finish_cycle();
    end
    dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle_and_compare();
      check("halt_mto", {31'd0, mem_timeout}, 32'd1);
      check("halt_enables", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'd0);
      check("halt_flushes", {28'd0, ifid_flush, idex_flush, exmem_flush, memwb_flush}, 32'd0);
      finish_cycle();
    end

    // Asynchronous reset from HALT.
    idle_inputs();
    reset_n = 1'b0;
    settle_and_compare();
    check("rst2_mto", {31'd0, mem_timeout}, 32'd0);
    check("rst2_flushes", {28'd0, ifid_flush, idex_flush, exmem_flush, memwb_flush}, 32'hF);
    finish_cycle();
    reset_n = 1'b1;

    // Randomized traffic with a small register range so hazards are frequent.
    for (int n = 0; n < 4000; n++) begin
      ifid_rs         = 5'($urandom_range(0, 3));
      ifid_rt         = 5'($urandom_range(0, 3));
      idex_rt         = 5'($urandom_range(0, 3));
      ifid_uses_rt    = 1'($urandom_range(0, 1));
      idex_mem_read   = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      exmem_mem_req   = 1'($urandom_range(0, 1));
      dmem_ready      = ($urandom_range(0, 3) != 0);
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 149) == 0) reset_n = 1'b0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
